aes_mem_responder: RTL and testbench

Memory-side responder for the HLS AES `workload` kernel's `ap_memory` data port, plus the `ap_ctrl_hs` start/done sequencer that launches it. It holds a 16-byte data buffer that the host preloads and reads back. It serves kernel reads with fixed one-cycle latency and absorbs kernel write-backs. It also counts reads and writes so the verification harness can bound kernel traffic and align transactions.

---
 rtl/aes_mem_responder.sv | 136 +++++++++++++
 tb/tb_aes_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mem_responder.sv
// aes_mem_responder: memory-side responder for the AES kernel's ap_memory
// data port plus the ap_ctrl_hs start/done sequencer that launches it.
// Handshake: the kernel control port follows ap_ctrl_hs. ap_start is held
// high from the cycle after a go until ap_ready is sampled high. ap_done
// sampled high ends the run, and done then pulses for exactly one cycle.
// Kernel memory requests (data_ce0) carry no ready and are always accepted
// while a run is active.
module aes_mem_responder #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          go,
    input  logic [AW-1:0] go_offset,
    input  logic          load_vld,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ap_start,
    input  logic          ap_ready,
    input  logic          ap_done,
    output logic [AW-1:0] data_offset,
    input  logic [AW-1:0] data_address0,
    input  logic          data_ce0,
    input  logic          data_we0,
    input  logic [DW-1:0] data_d0,
    output logic [DW-1:0] data_q0,
    output logic [4:0]    rd_count,
    output logic [4:0]    wr_count,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] mem [DEPTH];

    logic in_idle;
    logic active;
    logic k_rd;
    logic k_wr;
    logic h_ld;
    logic start_run;

    assign in_idle   = (state_q == S_IDLE);
    assign active    = (state_q == S_START) || (state_q == S_RUN);
    assign k_rd      = active && data_ce0 && !data_we0;
    assign k_wr      = active && data_ce0 && data_we0;
    assign h_ld      = in_idle && load_vld;
    assign start_run = in_idle && go;
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control outputs (all decoded from the current state).
    always_comb begin
        state_d  = state_q;
        ap_start = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_START;
            end
            S_START: begin
                ap_start = 1'b1;
                busy     = 1'b1;
                if (ap_ready) state_d = ap_done ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (ap_done) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Run bookkeeping: offset latch, saturating traffic counts, sticky error.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            data_offset <= '0;
            rd_count    <= 5'd0;
            wr_count    <= 5'd0;
            err         <= 1'b0;
        end else begin
            if (start_run) begin
                data_offset <= go_offset;
                rd_count    <= 5'd0;
                wr_count    <= 5'd0;
            end
            if (k_rd && rd_count != 5'd31) rd_count <= rd_count + 5'd1;
            if (k_wr && wr_count != 5'd31) wr_count <= wr_count + 5'd1;
            if ((data_ce0 && !active) || (load_vld && !in_idle) || (ap_done && in_idle))
                err <= 1'b1;
        end
    end

    // Registered read ports: kernel read data holds between reads; host dump
    // port samples every cycle so it tracks kernel writes one cycle later.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            data_q0   <= '0;
            dump_data <= '0;
        end else begin
            if (k_rd) data_q0 <= mem[data_address0];
            dump_data <= mem[dump_addr];
        end
    end

    // Buffer write port; contents deliberately survive reset.
    always_ff @(posedge ap_clk) begin
        if (k_wr)      mem[data_address0] <= data_d0;
        else if (h_ld) mem[load_addr]     <= load_data;
    end

endmodule

// File: tb/tb_aes_mem_responder.sv
// tb_aes_mem_responder: self-checking bench for aes_mem_responder.
module tb_aes_mem_responder;

    logic       ap_clk;
    logic       ap_rst;
    logic       go;
    logic [3:0] go_offset;
    logic       load_vld;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic [3:0] dump_addr;
    logic [7:0] dump_data;
    logic       busy;
    logic       done;
    logic       err;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic [3:0] data_offset;
    logic [3:0] data_address0;
    logic       data_ce0;
    logic       data_we0;
    logic [7:0] data_d0;
    logic [7:0] data_q0;
    logic [4:0] rd_count;
    logic [4:0] wr_count;
    logic [1:0] state_dbg;

    aes_mem_responder dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .go(go), .go_offset(go_offset),
        .load_vld(load_vld), .load_addr(load_addr), .load_data(load_data),
        .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy), .done(done),
        .err(err), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .data_offset(data_offset), .data_address0(data_address0),
        .data_ce0(data_ce0), .data_we0(data_we0), .data_d0(data_d0),
        .data_q0(data_q0), .rd_count(rd_count), .wr_count(wr_count),
        .state_dbg(state_dbg)
    );

    // Clock block.
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t vecs[6];

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: no expected entry queued, got %0h", name, data_q0);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(data_q0), 32'(e));
        end
    endtask

    // Driver: launch a run and bring it into RUN with a one-cycle ap_ready.
    task automatic start_run(input logic [3:0] off);
        go = 1'b1; go_offset = off;
        tick();
        go = 1'b0;
        check("start_ap_start", 32'(ap_start), 32'd1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
    endtask

    // Driver: finish a run through DONE back to IDLE.
    task automatic finish_run();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("finish_done", 32'(done), 32'd1);
        tick();
    endtask

    task automatic kread(input logic [3:0] a, input logic [7:0] e, input string name);
        data_ce0 = 1'b1; data_we0 = 1'b0; data_address0 = a;
        exp_q.push_back(e);
        tick();
        sb_check(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passes expected %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd4,  8'h14};
        vecs[1] = '{4'd5,  8'h15};
        vecs[2] = '{4'd0,  8'h10};
        vecs[3] = '{4'd15, 8'h1F};
        vecs[4] = '{4'd9,  8'h19};
        vecs[5] = '{4'd12, 8'h1C};

        ap_rst = 1'b1; go = 1'b0; go_offset = '0; load_vld = 1'b0; load_addr = '0;
        load_data = '0; dump_addr = '0; ap_ready = 1'b0; ap_done = 1'b0;
        data_address0 = '0; data_ce0 = 1'b0; data_we0 = 1'b0; data_d0 = '0;
        tick();
        tick();
        ap_rst = 1'b0;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ap_start", 32'(ap_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data_q0", 32'(data_q0), 32'd0);
        check("rst_dump_data", 32'(dump_data), 32'd0);
        check("rst_offset", 32'(data_offset), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);

        // Preload mem[i] = 0x10 + i.
        for (int i = 0; i < 16; i++) begin
            load_vld = 1'b1; load_addr = 4'(i); load_data = 8'(8'h10 + i);
            tick();
        end
        load_vld = 1'b0;

        // Table-driven kernel reads in one run at offset 4.
        start_run(4'd4);
        check("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            kread(vecs[i].addr, vecs[i].exp, "tbl_read");
            check("tbl_offset", 32'(data_offset), 32'd4);
            if (i == 1) check("tbl_rd_count2", 32'(rd_count), 32'd2);
        end
        data_ce0 = 1'b0;
        tick();
        check("q0_hold", 32'(data_q0), 32'h1C);
        check("tbl_rd_count6", 32'(rd_count), 32'd6);

        // Write then read-after-write to address 3.
        data_ce0 = 1'b1; data_we0 = 1'b1; data_address0 = 4'd3; data_d0 = 8'hA5;
        tick();
        check("wr_q0_unchanged", 32'(data_q0), 32'h1C);
        kread(4'd3, 8'hA5, "raw_read");
        data_ce0 = 1'b0;
        check("raw_wr_count", 32'(wr_count), 32'd1);
        check("raw_rd_count", 32'(rd_count), 32'd7);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        tick();
        check("done_cleared", 32'(done), 32'd0);
        dump_addr = 4'd3;
        tick();
        check("dump_a5", 32'(dump_data), 32'hA5);

        // ap_ready held low for 5 cycles.
        go = 1'b1; go_offset = 4'd1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("start_hold", 32'(ap_start), 32'd1);
            tick();
        end
        ap_ready = 1'b1;
        check("start_hold_last", 32'(ap_start), 32'd1);
        tick();
        ap_ready = 1'b0;
        check("start_drop", 32'(ap_start), 32'd0);
        check("run_busy2", 32'(busy), 32'd1);
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("slow_done", 32'(done), 32'd1);
        check("slow_busy", 32'(busy), 32'd0);
        tick();
        check("slow_done_once", 32'(done), 32'd0);
        check("slow_idle", 32'(state_dbg), 32'd0);

        // Illegal preload during RUN, then kernel accesses in IDLE.
        check("err_clear", 32'(err), 32'd0);
        start_run(4'd0);
        load_vld = 1'b1; load_addr = 4'd0; load_data = 8'hFF;
        tick();
        load_vld = 1'b0;
        check("err_load_run", 32'(err), 32'd1);
        finish_run();
        dump_addr = 4'd0;
        tick();
        check("mem0_kept", 32'(dump_data), 32'h10);
        data_ce0 = 1'b1; data_we0 = 1'b1; data_address0 = 4'd0; data_d0 = 8'h77;
        tick();
        data_we0 = 1'b0; data_address0 = 4'd5;
        tick();
        data_ce0 = 1'b0;
        check("idle_wr_count", 32'(wr_count), 32'd0);
        check("idle_rd_count", 32'(rd_count), 32'd0);
        check("idle_err", 32'(err), 32'd1);
        check("idle_q0", 32'(data_q0), 32'hA5);
        tick();
        check("idle_mem0", 32'(dump_data), 32'h10);

        // 40 reads saturate rd_count at 31.
        start_run(4'd8);
        for (int i = 0; i < 40; i++) begin
            kread(4'(i), (i % 16 == 3) ? 8'hA5 : 8'(8'h10 + (i % 16)), "sat_read");
        end
        data_ce0 = 1'b0;
        check("sat_rd_count", 32'(rd_count), 32'd31);
        finish_run();
        check("sat_hold", 32'(rd_count), 32'd31);
        go = 1'b1; go_offset = 4'd2;
        tick();
        go = 1'b0;
        check("go_clr_rd", 32'(rd_count), 32'd0);
        check("go_clr_wr", 32'(wr_count), 32'd0);
        check("go_offset2", 32'(data_offset), 32'd2);

        // Reset mid-run after a write to address 7.
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        data_ce0 = 1'b1; data_we0 = 1'b1; data_address0 = 4'd7; data_d0 = 8'h5A;
        tick();
        data_ce0 = 1'b0; data_we0 = 1'b0;
        check("mid_wr_count", 32'(wr_count), 32'd1);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("mid_rst_idle", 32'(state_dbg), 32'd0);
        check("mid_rst_start", 32'(ap_start), 32'd0);
        check("mid_rst_wr", 32'(wr_count), 32'd0);
        check("mid_rst_rd", 32'(rd_count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        dump_addr = 4'd7;
        tick();
        check("mid_rst_nodone", 32'(done), 32'd0);
        check("mem7_kept", 32'(dump_data), 32'h5A);

        // ap_done while idle is a protocol error.
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("err_done_idle", 32'(err), 32'd1);

        // Minimum run: ready and done together in the first START cycle.
        go = 1'b1; go_offset = 4'd0;
        tick();
        go = 1'b0;
        check("min_start", 32'(ap_start), 32'd1);
        ap_ready = 1'b1; ap_done = 1'b1;
        tick();
        ap_ready = 1'b0; ap_done = 1'b0;
        check("min_done", 32'(done), 32'd1);
        check("min_state", 32'(state_dbg), 32'd3);
        tick();
        check("min_idle", 32'(state_dbg), 32'd0);
        check("min_done_off", 32'(done), 32'd0);

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
